// File: rtl/ex_stage.sv
// RV32 execute stage: single-cycle ALU plus an iterative radix-2 divider that stalls upstream.
// Optional MUL/MULH/MULHSU/MULHU support is compiled in when EX_MUL_EN is defined.
module ex_stage #(
    parameter int DIV_CNT_W = 6,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      func3_i,
    input  logic [6:0]      func7_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    input  logic            annul_i,
    output logic [4:0]      wd_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            stall_req_o
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic                 neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic                 is_rem_q, is_rem_d, special_q, special_d;

    logic [XLEN-1:0] alu_res, div_res, a_abs, b_abs;
    logic [XLEN:0]   shifted, diff;
    logic            is_div, signed_op, a_neg, b_neg, stall;

    function automatic logic [XLEN-1:0] base_alu(input logic [2:0] f3, input logic sub,
                                                 input logic sra, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = sub ? a - b : a + b;
            3'b001:  r = a << b[4:0];
            3'b010:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011:  r = {{(XLEN-1){1'b0}}, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = sra ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

`ifdef EX_MUL_EN
    // 33x33 signed product covers all four signedness combinations of the MUL family.
    logic              mul_a_sgn, mul_b_sgn;
    logic signed [2*XLEN+1:0] prod;
    assign mul_a_sgn = (func3_i != 3'b011);
    assign mul_b_sgn = (func3_i == 3'b000) || (func3_i == 3'b001);
    assign prod = $signed({mul_a_sgn & reg1_i[XLEN-1], reg1_i})
                * $signed({mul_b_sgn & reg2_i[XLEN-1], reg2_i});
`endif

    always_comb begin
        alu_res = '0;
        case (opcode_i)
            OPC_OP: begin
                if (func7_i == F7_BASE)
                    alu_res = base_alu(func3_i, 1'b0, 1'b0, reg1_i, reg2_i);
                else if (func7_i == F7_ALT && (func3_i == 3'b000 || func3_i == 3'b101))
                    alu_res = base_alu(func3_i, 1'b1, 1'b1, reg1_i, reg2_i);
`ifdef EX_MUL_EN
                else if (func7_i == F7_MULDIV && !func3_i[2])
                    alu_res = (func3_i == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`endif
            end
            OPC_OP_IMM: alu_res = base_alu(func3_i, 1'b0, func7_i[5], reg1_i, reg2_i);
            OPC_LUI:    alu_res = reg2_i;
            default:    alu_res = '0;
        endcase
    end

    assign is_div    = (opcode_i == OPC_OP) && (func7_i == F7_MULDIV) && func3_i[2];
    assign signed_op = !func3_i[0];
    assign a_neg     = signed_op & reg1_i[XLEN-1];
    assign b_neg     = signed_op & reg2_i[XLEN-1];
    assign a_abs     = a_neg ? -reg1_i : reg1_i;
    assign b_abs     = b_neg ? -reg2_i : reg2_i;
    // Partial remainder is always below the divisor, so the shifted value fits in XLEN+1 bits.
    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        is_rem_d  = is_rem_q;
        special_d = special_q;
        stall     = 1'b0;
        if (annul_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (is_div) begin
                    stall    = 1'b1;
                    is_rem_d = func3_i[1];
                    neg_q_d  = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    dvs_d    = b_abs;
                    cnt_d    = '0;
                    if (reg2_i == '0) begin
                        quo_d = '1; rem_d = reg1_i; special_d = 1'b1; state_d = DONE;
                    end else if (signed_op && reg1_i == 32'h8000_0000 && reg2_i == '1) begin
                        quo_d = 32'h8000_0000; rem_d = '0; special_d = 1'b1; state_d = DONE;
                    end else begin
                        quo_d = a_abs; rem_d = '0; special_d = 1'b0; state_d = BUSY;
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                    rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DIV_CNT_W'(XLEN - 1))
                        state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            is_rem_q  <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            is_rem_q  <= is_rem_d;
            special_q <= special_d;
        end
    end

    // Special cases already hold their final signed values, so skip the fix-up for them.
    assign div_res = is_rem_q ? ((neg_r_q && !special_q) ? -rem_q : rem_q)
                              : ((neg_q_q && !special_q) ? -quo_q : quo_q);

    assign wd_o        = rst ? '0 : wd_i;
    assign wreg_o      = rst ? 1'b0 : (wreg_i & ~annul_i);
    assign stall_req_o = rst ? 1'b0 : stall;
    assign wdata_o     = (rst || stall) ? '0 : (state_q == DONE) ? div_res : alu_res;
endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, divider latency/results, annul and async reset.
module tb_ex_stage;
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] F0 = 7'b0000000, FA = 7'b0100000, FM = 7'b0000001;

    logic        clk = 1'b0, rst = 1'b1;
    logic [6:0]  opcode_i = '0, func7_i = '0;
    logic [2:0]  func3_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = 5'd5;
    logic        wreg_i = 1'b1, annul_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o, stall_req_o;
    logic [31:0] wdata_o;
    int passed = 0, total = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .opcode_i(opcode_i), .func3_i(func3_i), .func7_i(func7_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .annul_i(annul_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        opcode_i = op; func3_i = f3; func7_i = f7; reg1_i = a; reg2_i = b;
    endtask

    task automatic alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        drive(op, f3, f7, a, b);
        #1;
        chk({tag, "_data"}, wdata_o, exp);
        chk({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
        $display("alu %s a=0x%08h b=0x%08h wdata=0x%08h", tag, a, b, wdata_o);
        @(negedge clk);
    endtask

    // Holds the divide at the inputs while stalled, as the upstream pipeline would.
    task automatic div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stalls, input logic [31:0] exp);
        int n;
        drive(OP, f3, FM, a, b);
        #1;
        n = 0;
        while (stall_req_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
        chk({tag, "_data"}, wdata_o, exp);
        chk({tag, "_wreg"}, {31'd0, wreg_o}, 32'd1);
        $display("div %s a=0x%08h b=0x%08h stalls=%0d wdata=0x%08h", tag, a, b, n, wdata_o);
        @(negedge clk);
        drive(OP, 3'b000, F0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        drive(OP, 3'b000, F0, 32'd3, 32'd4);
        #1;
        chk("rst_wd", {27'd0, wd_o}, 32'd0);
        chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("pass_wd", {27'd0, wd_o}, 32'd5);
        chk("pass_wreg", {31'd0, wreg_o}, 32'd1);
        annul_i = 1'b1;
        #1;
        chk("annul_wreg", {31'd0, wreg_o}, 32'd0);
        annul_i = 1'b0;
        @(negedge clk);

        alu("add", OP, 3'b000, F0, 32'd3, 32'd4, 32'd7);
        alu("sub", OP, 3'b000, FA, 32'd3, 32'd4, 32'hFFFF_FFFF);
        alu("sra", OP, 3'b101, FA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu("sltu", OP, 3'b011, F0, 32'd1, 32'hFFFF_FFFF, 32'd1);
        alu("slt", OP, 3'b010, F0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("srl", OP, 3'b101, F0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu("addi", OPI, 3'b000, 7'b0100000, 32'hFFFF_FFFF, 32'd5, 32'd4);
        alu("srai", OPI, 3'b101, FA, 32'hF000_0000, 32'd8, 32'hFFF0_0000);
        alu("lui", LUI, 3'b000, F0, 32'd7, 32'h1234_5000, 32'h1234_5000);
        alu("badf7", OP, 3'b100, FA, 32'hFF, 32'h0F, 32'd0);
        alu("mul_off", OP, 3'b000, FM, 32'd6, 32'd7, 32'd0);

        div("divu", 3'b101, 32'd100, 32'd7, 33, 32'd14);
        div("remu", 3'b111, 32'd100, 32'd7, 33, 32'd2);
        div("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        div("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        div("divu_z", 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        div("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        div("div_z_rem", 3'b110, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9);

        drive(OP, 3'b100, FM, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        #1;
        chk("annul_stall", {31'd0, stall_req_o}, 32'd0);
        chk("annul_busy_wreg", {31'd0, wreg_o}, 32'd0);
        $display("annul busy stall=%0b wreg=%0b", stall_req_o, wreg_o);
        @(negedge clk);
        annul_i = 1'b0;
        alu("add_after", OP, 3'b000, F0, 32'd1, 32'd1, 32'd2);

        drive(OP, 3'b101, FM, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_wd", {27'd0, wd_o}, 32'd0);
        chk("midrst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("midrst_wdata", wdata_o, 32'd0);
        chk("midrst_stall", {31'd0, stall_req_o}, 32'd0);
        $display("async reset mid-divide stall=%0b wdata=0x%08h", stall_req_o, wdata_o);
        @(negedge clk);
        rst = 1'b0;
        div("divu_after_rst", 3'b101, 32'd9, 32'd3, 33, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32 pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its decoded fields.
- Computes RV32I ALU results combinationally.
- Runs DIV/DIVU/REM/REMU on an iterative radix-2 divider and stalls upstream stages through stall_req_o until the result is ready.
- Outputs feed the EX/MEM register.

Parameters:
- DIV_CNT_W, 6, width of the divider iteration counter; must hold 32.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset, asynchronous, active-high.
- opcode_i  input  7  opcode from ID/EX.
- func3_i  input  3  func3 from ID/EX.
- func7_i  input  7  func7 from ID/EX.
- reg1_i  input  32  operand 1 (rs1 value).
- reg2_i  input  32  operand 2 (rs2 value, or sign-extended immediate / U-immediate as placed by ID).
- wd_i  input  5  destination register address.
- wreg_i  input  1  write enable from ID.
- annul_i  input  1  flush of the current EX instruction (branch redirect).
- wd_o  output  5  destination address to EX/MEM.
- wreg_o  output  1  write enable to EX/MEM.
- wdata_o  output  32  result to EX/MEM.
- stall_req_o  output  1  hold PC, IF/ID and ID/EX this cycle.

Behaviour:
- Reset: clk and rst are one clock, with rst asynchronous and active-high. While rst=1: divider FSM=IDLE, counter=0, all internal regs=0. While rst=1, all outputs are forced to 0 (wd_o=0, wreg_o=0, wdata_o=0, stall_req_o=0).
- wd_o = wd_i and wreg_o = wreg_i combinationally, except: wreg_o=0 when annul_i=1.
- OP (0110011), func7=0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND by func3. Shift amount is reg2_i[4:0].
- OP, func7=0100000: SUB (func3 000), SRA (func3 101).
- OP-IMM (0010011): same ops using reg2_i as the immediate. func7[5] selects SRAI vs SRLI. No SUBI exists.
- LUI (0110111): wdata_o = reg2_i.
- Any other opcode/func combination: wdata_o = 0. ALU results are valid in the same cycle (0 latency).
- Divide ops: opcode OP, func7=0000001, func3 100=DIV, 101=DIVU, 110=REM, 111=REMU.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE with a divide op present and annul_i=0:
  - stall_req_o=1.
  - Latch |dividend|, |divisor| and result signs; signs are ignored for DIVU/REMU.
  - Divisor==0 -> DONE, quotient=0xFFFFFFFF, remainder=dividend.
  - Signed DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF -> DONE, quotient=0x80000000, remainder=0.
  - Otherwise -> BUSY with counter=0.
- BUSY: one restoring shift-subtract step per cycle. Counter increments each step. After the 32nd step (counter==31) -> DONE. stall_req_o=1 throughout.
- DONE:
  - Apply sign fix-up: quotient negative if signs differ; remainder takes the dividend's sign.
  - stall_req_o=0.
  - wdata_o = quotient (DIV/DIVU) or remainder (REM/REMU).
  - Next state IDLE.
- Normal divide: stall asserted 33 cycles; result presented in cycle 34 after the op arrives.
- Special-case divide: stall asserted 1 cycle; result in cycle 2.
- While stalled, wdata_o = 0.
- annul_i=1 in any state: next state IDLE, stall_req_o=0 in that same cycle, wreg_o=0.
- Back-to-back divides: the second divide arrives in the cycle after DONE, sees IDLE and starts normally.
- A non-divide op in IDLE never asserts stall_req_o.
- Async reset mid-divide: immediate return to IDLE with no result.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: opcode OP with func7=0000001 and func3 000/001/010/011 computes MUL/MULH/MULHSU/MULHU combinationally from a 33x33 signed product. Single cycle, no stall.
- Undefined: these encodings produce wdata_o=0, never stall, and wreg_o passes through unchanged.

Test Plan:
- ADD 3+4, SUB 3-4, SRA 0x80000000>>4, SLTU 1<0xFFFFFFFF -> wdata_o = 7, 0xFFFFFFFF, 0xF8000000, 1 in the same cycle; stall_req_o=0.
- DIVU 100/7 held at inputs while stall_req_o=1 -> stall high exactly 33 cycles, then wdata_o=14 for one cycle. REMU of the same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); each with 33 stall cycles.
- DIVU 5/0 -> 0xFFFFFFFF with 1 stall cycle. REM 0x80000000 / 0xFFFFFFFF -> 0 with 1 stall cycle.
- DIV in progress, annul_i=1 at BUSY cycle 10 -> stall_req_o=0 and wreg_o=0 that cycle. A following ADD 1+1 -> 2 with no stall.
- rst pulsed asynchronously mid-BUSY -> all outputs 0 immediately. After release, DIVU 9/3 takes the full 33-cycle stall and yields 3.
